bin_cnt_chk: RTL and testbench

Sequence checker for the 4-bit binary counter family: it samples a counter value stream and verifies that each sample is the previous one plus one, modulo 2^WIDTH. It acquires lock after a run of correct increments and counts sequence errors and wrap-arounds while locked. It sits on the consuming side of a counter output, either in-system or in a bench-side harness, and reports lock, error pulses and statistics.

---
 rtl/bin_cnt_chk_if.sv | 24 ++
 rtl/bin_cnt_chk.sv | 118 +++++++++++
 tb/tb_bin_cnt_chk.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/bin_cnt_chk_if.sv
// Sample/status bundle between a counter under check and the bin_cnt_chk sequence checker.
interface bin_cnt_chk_if #(
  parameter int WIDTH  = 4,
  parameter int STAT_W = 8
);
  logic              en;
  logic              clr;
  logic [WIDTH-1:0]  cnt_in;
  logic              locked;
  logic              err_pulse;
  logic [STAT_W-1:0] err_cnt;
  logic [STAT_W-1:0] wrap_cnt;
  logic [WIDTH-1:0]  exp_cnt;

  modport master (
    output en, clr, cnt_in,
    input  locked, err_pulse, err_cnt, wrap_cnt, exp_cnt
  );

  modport slave (
    input  en, clr, cnt_in,
    output locked, err_pulse, err_cnt, wrap_cnt, exp_cnt
  );
endinterface

// File: rtl/bin_cnt_chk.sv
// Binary counter sequence checker: verifies each sample is prev+1 mod 2^WIDTH,
// locks after RESYNC_N clean increments and counts errors and wraps while locked.
module bin_cnt_chk #(
    parameter int WIDTH    = 4,
    parameter int STAT_W   = 8,
    parameter int RESYNC_N = 2
) (
    input logic         clk,
    input logic         rst,
    bin_cnt_chk_if.slave bus
);

    localparam int RUN_W = $clog2(RESYNC_N + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACQ,
        LOCK
    } state_e;

    state_e            state_q;
    logic [WIDTH-1:0]  prev_q;
    logic [RUN_W-1:0]  run_q;
    logic              locked_q;
    logic              err_pulse_q;
    logic [STAT_W-1:0] err_cnt_q;
    logic [STAT_W-1:0] wrap_cnt_q;

    logic [WIDTH-1:0]  exp_cnt;
    logic              match;
    logic              wrap_hit;
    logic [RUN_W-1:0]  run_d;
    logic              run_done;
    logic [STAT_W-1:0] err_cnt_d;

    assign exp_cnt  = prev_q + WIDTH'(1);
    assign match    = (bus.cnt_in == exp_cnt);
    assign wrap_hit = (&prev_q) && (bus.cnt_in == '0);
    // run_q never exceeds RESYNC_N-1 while in ACQ, so the increment cannot overflow.
    assign run_d    = run_q + RUN_W'(1);
    assign run_done = (run_d == RUN_W'(RESYNC_N));

    // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (!(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + STAT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every branch reads the pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            prev_q      <= '0;
            run_q       <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            wrap_cnt_q  <= '0;
        end else if (bus.clr) begin
            // Clear drops lock and statistics but keeps the reference value.
            state_q     <= IDLE;
            run_q       <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            wrap_cnt_q  <= '0;
        end else begin
            err_pulse_q <= 1'b0;
            if (bus.en) begin
                prev_q <= bus.cnt_in;
                unique case (state_q)
                    IDLE: begin
                        run_q   <= '0;
                        state_q <= ACQ;
                    end
                    ACQ: begin
                        if (match) begin
                            run_q <= run_d;
                            if (run_done) begin
                                state_q  <= LOCK;
                                locked_q <= 1'b1;
                            end
                        end else begin
                            run_q <= '0;
                        end
                    end
                    LOCK: begin
                        if (match) begin
                            if (wrap_hit) begin
                                wrap_cnt_q <= wrap_cnt_q + STAT_W'(1);
                            end
                        end else begin
                            // Mismatching sample becomes the new reference for reacquisition.
                            err_pulse_q <= 1'b1;
                            err_cnt_q   <= err_cnt_d;
                            run_q       <= '0;
                            state_q     <= ACQ;
                            locked_q    <= 1'b0;
                        end
                    end
                    default: begin
                        state_q  <= IDLE;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.locked    = locked_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_cnt   = err_cnt_q;
    assign bus.wrap_cnt  = wrap_cnt_q;
    assign bus.exp_cnt   = exp_cnt;

endmodule

// File: tb/tb_bin_cnt_chk.sv
// Scoreboard bench for bin_cnt_chk: directed samples push hand-computed expectations, a monitor compares.
`timescale 1ns/1ps
module tb_bin_cnt_chk;

    typedef struct {
        bit          sel;
        logic        lk;
        logic        ep;
        logic [31:0] ec;
        logic [31:0] wc;
        logic [31:0] ex;
        string       tag;
    } exp_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_fail;
    int   pulse_b;
    exp_t sb_q[$];
    exp_t mon_x;

    bin_cnt_chk_if #(.WIDTH(4), .STAT_W(8)) bus_a ();
    bin_cnt_chk_if #(.WIDTH(4), .STAT_W(2)) bus_b ();

    bin_cnt_chk #(.WIDTH(4), .STAT_W(8), .RESYNC_N(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    bin_cnt_chk #(.WIDTH(4), .STAT_W(2), .RESYNC_N(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Drive one sample to the selected DUT (other one idles) and queue its expected response.
    task automatic step(input bit sel, input logic e, input logic c, input logic [3:0] v,
                        input logic lk, input logic ep, input int ec, input int wc,
                        input int ex, input string tag);
        exp_t x;
        if (!sel) begin
            bus_a.en = e;    bus_a.clr = c;    bus_a.cnt_in = v;
            bus_b.en = 1'b0; bus_b.clr = 1'b0;
        end else begin
            bus_b.en = e;    bus_b.clr = c;    bus_b.cnt_in = v;
            bus_a.en = 1'b0; bus_a.clr = 1'b0;
        end
        x.sel = sel; x.lk = lk; x.ep = ep;
        x.ec = 32'(ec); x.wc = 32'(wc); x.ex = 32'(ex); x.tag = tag;
        sb_q.push_back(x);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: outputs are sampled 2 ns after each rising edge and matched to the oldest expectation.
    always begin
        @(posedge clk);
        #2;
        if (sb_q.size() > 0) begin
            mon_x = sb_q.pop_front();
            if (!mon_x.sel) begin
                check({mon_x.tag, ".locked"},    32'(bus_a.locked),    32'(mon_x.lk));
                check({mon_x.tag, ".err_pulse"}, 32'(bus_a.err_pulse), 32'(mon_x.ep));
                check({mon_x.tag, ".err_cnt"},   32'(bus_a.err_cnt),   mon_x.ec);
                check({mon_x.tag, ".wrap_cnt"},  32'(bus_a.wrap_cnt),  mon_x.wc);
                check({mon_x.tag, ".exp_cnt"},   32'(bus_a.exp_cnt),   mon_x.ex);
            end else begin
                check({mon_x.tag, ".locked"},    32'(bus_b.locked),    32'(mon_x.lk));
                check({mon_x.tag, ".err_pulse"}, 32'(bus_b.err_pulse), 32'(mon_x.ep));
                check({mon_x.tag, ".err_cnt"},   32'(bus_b.err_cnt),   mon_x.ec);
                check({mon_x.tag, ".wrap_cnt"},  32'(bus_b.wrap_cnt),  mon_x.wc);
                check({mon_x.tag, ".exp_cnt"},   32'(bus_b.exp_cnt),   mon_x.ex);
            end
        end
    end

    always begin
        @(posedge clk);
        #2;
        if (bus_b.err_pulse === 1'b1) pulse_b++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within 100000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p;
        int m;
        int ecx;
        n_vec = 0; n_fail = 0; pulse_b = 0;
        rst = 1'b0;
        bus_a.en = 1'b0; bus_a.clr = 1'b0; bus_a.cnt_in = '0;
        bus_b.en = 1'b0; bus_b.clr = 1'b0; bus_b.cnt_in = '0;

        // Reset held 100 ns with random stimulus.
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            step(0, 1'($urandom_range(0, 1)), 1'b0, 4'($urandom_range(0, 15)),
                 0, 0, 0, 0, 1, $sformatf("rst%0d", i));
        end
        rst = 1'b1;

        // Clean stream 0..15,0,1: lock after sampling 2, one wrap after 15->0.
        for (int i = 0; i < 18; i++) begin
            step(0, 1, 0, 4'(i), (i >= 2), 0, 0, (i >= 16) ? 1 : 0, (i + 1) % 16,
                 $sformatf("clean%0d", i));
        end

        // Upstream counter reset mid-count.
        for (int v = 2; v <= 7; v++) step(0, 1, 0, 4'(v), 1, 0, 0, 1, v + 1, $sformatf("up%0d", v));
        step(0, 1, 0, 4'd0, 0, 1, 1, 1, 1, "up_rst0");
        step(0, 1, 0, 4'd1, 0, 0, 1, 1, 2, "up_rst1");
        step(0, 1, 0, 4'd2, 1, 0, 1, 1, 3, "up_rst2");
        step(0, 1, 0, 4'd3, 1, 0, 1, 1, 4, "up_rst3");

        // Hold with en=0, then clr together with a mismatching sample.
        for (int v = 4; v <= 9; v++) step(0, 1, 0, 4'(v), 1, 0, 1, 1, v + 1, $sformatf("to9_%0d", v));
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 4'($urandom_range(0, 15)), 1, 0, 1, 1, 10, $sformatf("hold%0d", i));
        end
        step(0, 1, 1, 4'd5, 0, 0, 0, 0, 10, "clr");
        step(0, 1, 0, 4'd10, 0, 0, 0, 0, 11, "relock10");
        step(0, 1, 0, 4'd11, 0, 0, 0, 0, 12, "relock11");
        step(0, 1, 0, 4'd12, 1, 0, 0, 0, 13, "relock12");

        // Repeated value and skip both count as mismatches.
        step(0, 1, 0, 4'd12, 0, 1, 1, 0, 13, "repeat12");
        step(0, 1, 0, 4'd13, 0, 0, 1, 0, 14, "acq13");
        step(0, 1, 0, 4'd14, 1, 0, 1, 0, 15, "lock14");
        step(0, 1, 0, 4'd0,  0, 1, 2, 0, 1,  "skip0");
        step(0, 1, 0, 4'd1,  0, 0, 2, 0, 2,  "acq1");
        step(0, 1, 0, 4'd2,  1, 0, 2, 0, 3,  "lock2");

        // Asynchronous reset 5 ns after a rising edge, checked before the next edge.
        @(posedge clk);
        #5 rst = 1'b0;
        #1;
        check("async.locked",    32'(bus_a.locked),    32'd0);
        check("async.err_pulse", 32'(bus_a.err_pulse), 32'd0);
        check("async.err_cnt",   32'(bus_a.err_cnt),   32'd0);
        check("async.wrap_cnt",  32'(bus_a.wrap_cnt),  32'd0);
        check("async.exp_cnt",   32'(bus_a.exp_cnt),   32'd1);
        @(negedge clk);
        step(0, 1, 0, 4'd7, 0, 0, 0, 0, 1, "async_hold");
        rst = 1'b1;
        step(0, 1, 0, 4'd3, 0, 0, 0, 0, 4, "post3");
        step(0, 1, 0, 4'd4, 0, 0, 0, 0, 5, "post4");
        step(0, 1, 0, 4'd5, 1, 0, 0, 0, 6, "post5");

        // Saturation on the 2-bit statistics instance: 5 mismatches from LOCK.
        step(1, 1, 0, 4'd0, 0, 0, 0, 0, 1, "sat_a0");
        step(1, 1, 0, 4'd1, 0, 0, 0, 0, 2, "sat_a1");
        step(1, 1, 0, 4'd2, 1, 0, 0, 0, 3, "sat_a2");
        p = 2;
        for (int r = 0; r < 5; r++) begin
            m   = (p + 5) % 16;
            ecx = (r + 1 > 3) ? 3 : r + 1;
            step(1, 1, 0, 4'(m),     0, 1, ecx, 0, (m + 1) % 16, $sformatf("sat_err%0d", r));
            step(1, 1, 0, 4'(m + 1), 0, 0, ecx, 0, (m + 2) % 16, $sformatf("sat_acq%0d", r));
            step(1, 1, 0, 4'(m + 2), 1, 0, ecx, 0, (m + 3) % 16, $sformatf("sat_lock%0d", r));
            p = (m + 2) % 16;
        end
        bus_b.en = 1'b0;

        check("sat.pulse_cycles", 32'(pulse_b), 32'd5);
        check("scoreboard.drained", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
